shwr_baseline_tracker: RTL and testbench
========================================

SHWR_BASELINE_TRACKER -- requirements
Module: shwr_baseline_tracker

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ADC_WIDTH, 12, ADC sample width.
- EXTRA_BITS, 3, fractional baseline bits (SHWR_BASELINE_EXTRA_BITS).
- WIN_LOG2, 5, log2 of samples per averaging window; must be >= EXTRA_BITS.
- QUIET_DELTA, 20, max ADC counts above integer baseline for a clean sample.
- HOLDOFF, 64, samples to wait after a discarded window.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- CLK, in, 1, 120 MHz clock.
- RST_N, in, 1, asynchronous active-low reset.
- ENABLE40, in, 1, clock enable marking a 40 MHz sample.
- ADC_IN, in, ADC_WIDTH, filtered ADC sample.
- VETO, in, 1, shower/trigger activity; sample is not quiet.
- RESTART, in, 1, synchronous request to re-acquire the baseline.
- BASELINE, out, ADC_WIDTH+EXTRA_BITS, baseline in fixed-point int.frac format; feeds the deconvolution BASELINE input.
- BASELINE_VALID, out, 1, a baseline has been acquired since reset/RESTART.
- DISCARD_COUNT, out, 16, number of discarded windows, saturating.

Function
REQ-003 Samples SHALL be processed only on CLK edges where ENABLE40=1; all state SHALL hold otherwise, except RESTART handling.
REQ-004 The state machine SHALL have three states: INIT (acquire), TRACK (slow follow), HOLD (holdoff after a disturbance).
REQ-005 The accumulator SHALL be ADC_WIDTH+WIN_LOG2 bits wide and SHALL sum the 2^WIN_LOG2 samples of the current window; the sample counter SHALL be WIN_LOG2 bits.
REQ-006 Window mean SHALL be accumulator >> (WIN_LOG2-EXTRA_BITS), truncated, in the same format as BASELINE.
REQ-007 A sample SHALL be dirty in INIT if VETO=1; in TRACK if VETO=1 or ADC_IN > min(BASELINE int part + QUIET_DELTA, 2^ADC_WIDTH-1).
REQ-008 On a dirty sample: accumulator and counter cleared; DISCARD_COUNT +1, saturating at 65535; INIT stays in INIT (restart window); TRACK goes to HOLD with the holdoff counter loaded to HOLDOFF-1.
REQ-009 In HOLD, each ENABLE40 SHALL decrement the holdoff counter; at 0 the block SHALL go to TRACK on that edge with a cleared window. ADC_IN and VETO are ignored in HOLD.
REQ-010 INIT completion: on the ENABLE40 edge that accepts the final clean sample, BASELINE SHALL load the window mean on the next CLK edge, BASELINE_VALID SHALL go to 1, and the state SHALL go to TRACK.
REQ-011 TRACK completion: on the same timing as REQ-010, BASELINE SHALL change by exactly one LSB toward the mean: +1 if mean > BASELINE, -1 if mean < BASELINE, unchanged if equal. It SHALL never wrap below 0 or above all-ones.
REQ-012 The accumulator and counter SHALL restart for the next window on the completion edge, with no sample lost.
REQ-013 RESTART=1 SHALL, on any CLK edge (ENABLE40 ignored), take priority over all other events:
- state goes to INIT;
- accumulator, sample counter and holdoff counter cleared;
- BASELINE_VALID cleared;
- BASELINE and DISCARD_COUNT hold.
REQ-014 A RESTART coinciding with a window completion SHALL suppress that update.
REQ-015 All outputs SHALL be registered; BASELINE SHALL change only at window completion or reset.

Reset
REQ-016 RST_N=0 SHALL asynchronously force:
- state INIT;
- BASELINE=0, BASELINE_VALID=0, DISCARD_COUNT=0;
- accumulator and all counters = 0.
REQ-017 Release of RST_N SHALL begin a fresh INIT window at the first subsequent ENABLE40.

Verification (defaults, ENABLE40 every 3rd CLK)
REQ-018 Constant ADC_IN=300, VETO=0 after reset -> BASELINE=2400 and VALID=1 one CLK after the 32nd sampled edge.
REQ-019 After REQ-018, ADC_IN=301 constant -> BASELINE 2401 after next window; 2408 after 8 windows, then stable.
REQ-020 In TRACK at 2400, one sample of 321 mid-window -> window discarded, DISCARD_COUNT=1. HOLD lasts 64 samples with a 4000-count pulse ignored, then 32 clean samples leave BASELINE=2400.
REQ-021 VETO pulsed on sample 10 of the INIT window -> VALID stays 0; acquisition completes 32 clean samples after the veto.
REQ-022 RESTART asserted on a non-ENABLE40 cycle mid-TRACK at BASELINE=2400, ADC_IN=500 -> VALID=0 next CLK, BASELINE holds 2400, then 4000 after 32 samples (INIT skips the quiet check).
REQ-023 RST_N low mid-HOLD, between CLK edges -> all outputs 0 immediately; normal acquisition after release.

Source files
------------

// File: rtl/shwr_baseline_tracker_if.sv
// Sample/control inputs and baseline outputs of the shower baseline tracker.
// The master drives samples; the tracker is the slave.
interface shwr_baseline_tracker_if #(
  parameter int unsigned ADC_WIDTH  = 12,
  parameter int unsigned EXTRA_BITS = 3
);
  logic                            ENABLE40;
  logic [ADC_WIDTH-1:0]            ADC_IN;
  logic                            VETO;
  logic                            RESTART;
  logic [ADC_WIDTH+EXTRA_BITS-1:0] BASELINE;
  logic                            BASELINE_VALID;
  logic [15:0]                     DISCARD_COUNT;

  modport master (
    output ENABLE40, ADC_IN, VETO, RESTART,
    input  BASELINE, BASELINE_VALID, DISCARD_COUNT
  );

  modport slave (
    input  ENABLE40, ADC_IN, VETO, RESTART,
    output BASELINE, BASELINE_VALID, DISCARD_COUNT
  );
endinterface

// File: rtl/shwr_baseline_tracker.sv
// Quiet-sample baseline estimator: acquires a windowed mean, then follows it by one
// fractional LSB per clean window, backing off for a holdoff period after disturbances.
module shwr_baseline_tracker #(
  parameter int unsigned ADC_WIDTH   = 12,
  parameter int unsigned EXTRA_BITS  = 3,
  parameter int unsigned WIN_LOG2    = 5,
  parameter int unsigned QUIET_DELTA = 20,
  parameter int unsigned HOLDOFF     = 64
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  shwr_baseline_tracker_if.slave bus
);

  localparam int unsigned AccW  = ADC_WIDTH + WIN_LOG2;
  localparam int unsigned BlW   = ADC_WIDTH + EXTRA_BITS;
  localparam int unsigned Shift = WIN_LOG2 - EXTRA_BITS;
  localparam int unsigned LimW  = ADC_WIDTH + 1;
  localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {StInit, StTrack, StHold} state_e;

  state_e               state_q, state_d;
  logic [AccW-1:0]      acc_q, acc_d;
  logic [WIN_LOG2-1:0]  cnt_q, cnt_d;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic [BlW-1:0]       baseline_q, baseline_d;
  logic                 valid_q, valid_d;
  logic [15:0]          disc_q, disc_d;

  logic [AccW-1:0]      acc_sum;
  logic [BlW-1:0]       mean;
  logic [LimW-1:0]      quiet_lim;
  logic                 too_high;
  logic                 dirty;
  logic                 win_done;

  assign acc_sum   = acc_q + AccW'(bus.ADC_IN);
  assign mean      = acc_sum[AccW-1:Shift];
  assign win_done  = (cnt_q == '1);
  // One extra bit keeps int+delta from wrapping, which makes the clamp to full scale implicit.
  assign quiet_lim = {1'b0, baseline_q[BlW-1:EXTRA_BITS]} + LimW'(QUIET_DELTA);
  assign too_high  = ({1'b0, bus.ADC_IN} > quiet_lim);
  assign dirty     = bus.VETO || ((state_q == StTrack) && too_high);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    baseline_d = baseline_q;
    valid_d    = valid_q;
    disc_d     = disc_q;

    if (bus.RESTART) begin
      state_d = StInit;
      acc_d   = '0;
      cnt_d   = '0;
      hold_d  = '0;
      valid_d = 1'b0;
    end else if (bus.ENABLE40) begin
      case (state_q)
        StInit, StTrack: begin
          if (dirty) begin
            acc_d = '0;
            cnt_d = '0;
            if (disc_q != '1) disc_d = disc_q + 16'd1;
            if (state_q == StTrack) begin
              state_d = StHold;
              hold_d  = HoldW'(HOLDOFF - 1);
            end
          end else if (win_done) begin
            acc_d = '0;
            cnt_d = '0;
            if (state_q == StInit) begin
              baseline_d = mean;
              valid_d    = 1'b1;
              state_d    = StTrack;
            end else if ((mean > baseline_q) && (baseline_q != '1)) begin
              baseline_d = baseline_q + BlW'(1);
            end else if ((mean < baseline_q) && (baseline_q != '0)) begin
              baseline_d = baseline_q - BlW'(1);
            end
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + WIN_LOG2'(1);
          end
        end
        StHold: begin
          if (hold_q == '0) begin
            state_d = StTrack;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            hold_d = hold_q - HoldW'(1);
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StInit;
      acc_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      baseline_q <= '0;
      valid_q    <= 1'b0;
      disc_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      baseline_q <= baseline_d;
      valid_q    <= valid_d;
      disc_q     <= disc_d;
    end
  end

  assign bus.BASELINE       = baseline_q;
  assign bus.BASELINE_VALID = valid_q;
  assign bus.DISCARD_COUNT  = disc_q;

endmodule

// File: tb/tb_shwr_baseline_tracker.sv
// Bench for shwr_baseline_tracker: directed scenarios plus randomized stimulus checked
// against a window-of-samples reference model.
module tb_shwr_baseline_tracker;

  localparam int Win     = 32;
  localparam int HoldOff = 64;
  localparam int Qd      = 20;
  localparam int MInit   = 0;
  localparam int MTrack  = 1;
  localparam int MHold   = 2;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  shwr_baseline_tracker_if #(.ADC_WIDTH(12), .EXTRA_BITS(3)) bus ();

  shwr_baseline_tracker #(
    .ADC_WIDTH(12), .EXTRA_BITS(3), .WIN_LOG2(5), .QUIET_DELTA(Qd), .HOLDOFF(HoldOff)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of clean samples in the current window, mode, holdoff remaining.
  int m_mode;
  int m_win[$];
  int m_hold;
  int m_base;
  int m_disc;
  bit m_valid;

  function void model_reset();
    m_mode = MInit; m_win.delete(); m_hold = 0; m_base = 0; m_valid = 0; m_disc = 0;
  endfunction

  function void model_edge(bit en, int adc, bit veto, bit rs);
    int lim, sum, mean;
    if (!RST_N) begin model_reset(); return; end
    if (rs) begin
      m_mode = MInit; m_win.delete(); m_hold = 0; m_valid = 0;
      return;
    end
    if (!en) return;
    if (m_mode == MHold) begin
      if (m_hold == 0) begin m_mode = MTrack; m_win.delete(); end
      else m_hold--;
      return;
    end
    lim = m_base / 8 + Qd;
    if (lim > 4095) lim = 4095;
    if (veto || (m_mode == MTrack && adc > lim)) begin
      m_win.delete();
      if (m_disc < 65535) m_disc++;
      if (m_mode == MTrack) begin m_mode = MHold; m_hold = HoldOff - 1; end
      return;
    end
    m_win.push_back(adc);
    if (m_win.size() == Win) begin
      sum = 0;
      foreach (m_win[i]) sum += m_win[i];
      mean = sum / 4;
      if (m_mode == MInit) begin
        m_base = mean; m_valid = 1; m_mode = MTrack;
      end else if (mean > m_base) m_base++;
      else if (mean < m_base) m_base--;
      m_win.delete();
    end
  endfunction

  task automatic step(bit en, int adc, bit veto, bit rs);
    bus.ENABLE40 = en;
    bus.ADC_IN   = 12'(adc);
    bus.VETO     = veto;
    bus.RESTART  = rs;
    @(posedge CLK);
    model_edge(en, adc, veto, rs);
    #1;
  endtask

  task automatic sample(int adc, bit veto);
    step(1'b1, adc, veto, 1'b0);
    step(1'b0, adc, 1'b0, 1'b0);
    step(1'b0, adc, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bus.ENABLE40 = 0; bus.ADC_IN = '0; bus.VETO = 0; bus.RESTART = 0;
    RST_N = 1'b0;
    model_reset();
    repeat (3) step(1'b1, 300, 1'b0, 1'b0);
    n_checks++;
    if (bus.BASELINE !== 15'd0 || bus.BASELINE_VALID !== 1'b0 || bus.DISCARD_COUNT !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got base=%0d valid=%0b disc=%0d expected 0/0/0",
               bus.BASELINE, bus.BASELINE_VALID, bus.DISCARD_COUNT);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_acquire();
    repeat (Win - 1) sample(300, 1'b0);
    n_checks++;
    if (bus.BASELINE_VALID !== 1'b0) begin
      n_fail++; $display("FAIL acq_valid_early: got %0b expected 0", bus.BASELINE_VALID);
    end
    step(1'b1, 300, 1'b0, 1'b0);
    n_checks++;
    if (bus.BASELINE !== 15'd2400 || bus.BASELINE_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL acq_done: got base=%0d valid=%0b expected 2400/1",
               bus.BASELINE, bus.BASELINE_VALID);
    end
    step(1'b0, 300, 1'b0, 1'b0);
    step(1'b0, 300, 1'b0, 1'b0);
  endtask

  task automatic test_track_up();
    for (int w = 1; w <= 9; w++) begin
      repeat (Win) sample(301, 1'b0);
      n_checks++;
      if (bus.BASELINE !== 15'((w > 8) ? 2408 : 2400 + w)) begin
        n_fail++;
        $display("FAIL track_step w%0d: got %0d expected %0d", w, bus.BASELINE,
                 (w > 8) ? 2408 : 2400 + w);
      end
    end
  endtask

  task automatic test_quiet_boundary();
    step(1'b0, 300, 1'b0, 1'b1);
    n_checks++;
    if (bus.BASELINE !== 15'd2408 || bus.BASELINE_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_hold: got base=%0d valid=%0b expected 2408/0",
               bus.BASELINE, bus.BASELINE_VALID);
    end
    repeat (Win) sample(300, 1'b0);
    // 320 sits exactly at int(2400)+20 so it is still clean: mean 2405 -> step up.
    repeat (Win - 1) sample(300, 1'b0);
    sample(320, 1'b0);
    n_checks++;
    if (bus.BASELINE !== 15'd2401 || bus.DISCARD_COUNT !== 16'd0) begin
      n_fail++;
      $display("FAIL quiet_edge: got base=%0d disc=%0d expected 2401/0",
               bus.BASELINE, bus.DISCARD_COUNT);
    end
    repeat (Win) sample(299, 1'b0);
    n_checks++;
    if (bus.BASELINE !== 15'd2400) begin
      n_fail++; $display("FAIL track_down: got %0d expected 2400", bus.BASELINE);
    end
  endtask

  task automatic test_discard();
    repeat (10) sample(300, 1'b0);
    sample(321, 1'b0);
    n_checks++;
    if (bus.DISCARD_COUNT !== 16'd1) begin
      n_fail++; $display("FAIL discard_count: got %0d expected 1", bus.DISCARD_COUNT);
    end
    for (int i = 0; i < HoldOff; i++) sample((i == 20) ? 4000 : 300, i == 20);
    n_checks++;
    if (bus.DISCARD_COUNT !== 16'd1 || bus.BASELINE !== 15'd2400) begin
      n_fail++;
      $display("FAIL hold_ignore: got disc=%0d base=%0d expected 1/2400",
               bus.DISCARD_COUNT, bus.BASELINE);
    end
    repeat (Win) sample(300, 1'b0);
    n_checks++;
    if (bus.BASELINE !== 15'd2400) begin
      n_fail++; $display("FAIL after_hold: got %0d expected 2400", bus.BASELINE);
    end
    // Window alignment after the holdoff shows its exact length.
    sample(330, 1'b0);
    repeat (HoldOff) sample(300, 1'b0);
    repeat (Win - 1) sample(300, 1'b0);
    sample(308, 1'b0);
    n_checks++;
    if (bus.BASELINE !== 15'd2401 || bus.DISCARD_COUNT !== 16'd2) begin
      n_fail++;
      $display("FAIL hold_length: got base=%0d disc=%0d expected 2401/2",
               bus.BASELINE, bus.DISCARD_COUNT);
    end
  endtask

  task automatic test_init_veto();
    step(1'b0, 300, 1'b0, 1'b1);
    repeat (9) sample(300, 1'b0);
    sample(300, 1'b1);
    n_checks++;
    if (bus.DISCARD_COUNT !== 16'd3 || bus.BASELINE_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL init_veto: got disc=%0d valid=%0b expected 3/0",
               bus.DISCARD_COUNT, bus.BASELINE_VALID);
    end
    repeat (Win - 1) sample(300, 1'b0);
    n_checks++;
    if (bus.BASELINE_VALID !== 1'b0 || bus.BASELINE !== 15'd2401) begin
      n_fail++;
      $display("FAIL init_veto_wait: got valid=%0b base=%0d expected 0/2401",
               bus.BASELINE_VALID, bus.BASELINE);
    end
    sample(300, 1'b0);
    n_checks++;
    if (bus.BASELINE_VALID !== 1'b1 || bus.BASELINE !== 15'd2400) begin
      n_fail++;
      $display("FAIL init_veto_done: got valid=%0b base=%0d expected 1/2400",
               bus.BASELINE_VALID, bus.BASELINE);
    end
  endtask

  task automatic test_restart_track();
    repeat (10) sample(300, 1'b0);
    step(1'b0, 500, 1'b0, 1'b1);
    n_checks++;
    if (bus.BASELINE_VALID !== 1'b0 || bus.BASELINE !== 15'd2400) begin
      n_fail++;
      $display("FAIL restart_mid: got valid=%0b base=%0d expected 0/2400",
               bus.BASELINE_VALID, bus.BASELINE);
    end
    repeat (Win) sample(500, 1'b0);
    n_checks++;
    if (bus.BASELINE !== 15'd4000 || bus.BASELINE_VALID !== 1'b1 || bus.DISCARD_COUNT !== 16'd3) begin
      n_fail++;
      $display("FAIL restart_reacq: got base=%0d valid=%0b disc=%0d expected 4000/1/3",
               bus.BASELINE, bus.BASELINE_VALID, bus.DISCARD_COUNT);
    end
  endtask

  task automatic test_restart_completion();
    repeat (Win - 1) sample(520, 1'b0);
    step(1'b1, 520, 1'b0, 1'b1);
    n_checks++;
    if (bus.BASELINE !== 15'd4000 || bus.BASELINE_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_suppress: got base=%0d valid=%0b expected 4000/0",
               bus.BASELINE, bus.BASELINE_VALID);
    end
    step(1'b0, 300, 1'b0, 1'b0);
    step(1'b0, 300, 1'b0, 1'b0);
    repeat (Win) sample(300, 1'b0);
    n_checks++;
    if (bus.BASELINE !== 15'd2400 || bus.BASELINE_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clean_win: got base=%0d valid=%0b expected 2400/1",
               bus.BASELINE, bus.BASELINE_VALID);
    end
  endtask

  task automatic test_reset_hold();
    sample(400, 1'b0);
    repeat (5) sample(300, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (bus.BASELINE !== 15'd0 || bus.BASELINE_VALID !== 1'b0 || bus.DISCARD_COUNT !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: got base=%0d valid=%0b disc=%0d expected 0/0/0",
               bus.BASELINE, bus.BASELINE_VALID, bus.DISCARD_COUNT);
    end
    model_reset();
    step(1'b1, 300, 1'b0, 1'b0);
    step(1'b0, 300, 1'b0, 1'b0);
    RST_N = 1'b1;
    repeat (Win) sample(300, 1'b0);
    n_checks++;
    if (bus.BASELINE !== 15'd2400 || bus.BASELINE_VALID !== 1'b1 || bus.DISCARD_COUNT !== 16'd0) begin
      n_fail++;
      $display("FAIL post_reset_acq: got base=%0d valid=%0b disc=%0d expected 2400/1/0",
               bus.BASELINE, bus.BASELINE_VALID, bus.DISCARD_COUNT);
    end
  endtask

  task automatic test_random();
    int adc, r, shown;
    bit en, veto, rs;
    shown = 0;
    for (int i = 0; i < 6000; i++) begin
      en   = ($urandom_range(0, 2) == 0);
      veto = ($urandom_range(0, 199) == 0);
      rs   = ($urandom_range(0, 499) == 0);
      r    = int'($urandom_range(0, 99));
      if (r < 2) adc = int'($urandom_range(0, 4095));
      else adc = m_base / 8 + int'($urandom_range(0, 22)) - 8;
      if (adc < 0) adc = 0;
      if (adc > 4095) adc = 4095;
      step(en, adc, veto, rs);
      n_checks++;
      if (bus.BASELINE !== 15'(m_base) || bus.BASELINE_VALID !== m_valid ||
          bus.DISCARD_COUNT !== 16'(m_disc)) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle %0d: got base=%0d valid=%0b disc=%0d expected %0d/%0b/%0d",
                   i, bus.BASELINE, bus.BASELINE_VALID, bus.DISCARD_COUNT,
                   m_base, m_valid, m_disc);
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_acquire();
    test_track_up();
    test_quiet_boundary();
    test_discard();
    test_init_veto();
    test_restart_track();
    test_restart_completion();
    test_reset_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
